// File: rtl/vec_register_file.sv
// Vector register file: registerQuantity vectors of vectorSize lanes x registerSize bits,
// two combinational read ports and one synchronous write port.
module vec_register_file #(
  parameter int registerSize     = 8,
  parameter int registerQuantity = 4,
  parameter int selectionBits    = 2,
  parameter int vectorSize       = 4
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   regWrEn,
  input  logic [selectionBits-1:0]               rSel1,
  input  logic [selectionBits-1:0]               rSel2,
  input  logic [selectionBits-1:0]               regToWrite,
  input  logic [vectorSize-1:0][registerSize-1:0] regWriteData,
  output logic [vectorSize-1:0][registerSize-1:0] reg1Out,
  output logic [vectorSize-1:0][registerSize-1:0] reg2Out
);

  typedef logic [vectorSize-1:0][registerSize-1:0] vec_t;

  vec_t regs_q [registerQuantity];
  vec_t regs_d [registerQuantity];

  logic wr_in_range;
  logic rd1_in_range;
  logic rd2_in_range;

  assign wr_in_range  = 32'(regToWrite) < 32'(registerQuantity);
  assign rd1_in_range = 32'(rSel1) < 32'(registerQuantity);
  assign rd2_in_range = 32'(rSel2) < 32'(registerQuantity);

  always_comb begin
    regs_d = regs_q;
    if (regWrEn && wr_in_range) begin
      regs_d[regToWrite] = regWriteData;
    end
  end

  // Reset wins over a same-edge write, so the write is simply dropped here.
  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    reg1Out = '0;
    reg2Out = '0;
    if (rd1_in_range) begin
      reg1Out = regs_q[rSel1];
    end
    if (rd2_in_range) begin
      reg2Out = regs_q[rSel2];
    end
  end

endmodule

// File: tb/tb_vec_register_file.sv
// Directed self-checking bench for vec_register_file using the default geometry
// (4 registers x 4 lanes x 8 bits).
module tb_vec_register_file;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 regWrEn;
  logic [1:0]           rSel1;
  logic [1:0]           rSel2;
  logic [1:0]           regToWrite;
  logic [3:0][7:0]      regWriteData;
  logic [3:0][7:0]      reg1Out;
  logic [3:0][7:0]      reg2Out;

  int checks = 0;
  int errors = 0;

  vec_register_file dut (
    .clk          (clk),
    .reset        (reset),
    .regWrEn      (regWrEn),
    .rSel1        (rSel1),
    .rSel2        (rSel2),
    .regToWrite   (regToWrite),
    .regWriteData (regWriteData),
    .reg1Out      (reg1Out),
    .reg2Out      (reg2Out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then move 1 time unit past it before driving/sampling.
  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset        = 1'b1;
    regWrEn      = 1'b0;
    rSel1        = 2'd0;
    rSel2        = 2'd0;
    regToWrite   = 2'd0;
    regWriteData = 32'h0;

    // Reset
    edge_step();
    chk("reset_r1", reg1Out, 32'h0);
    chk("reset_r2", reg2Out, 32'h0);
    for (int i = 0; i < 4; i++) begin
      rSel1 = 2'(i);
      rSel2 = 2'(3 - i);
      #1;
      chk($sformatf("reset_sweep_r1_%0d", i), reg1Out, 32'h0);
      chk($sformatf("reset_sweep_r2_%0d", i), reg2Out, 32'h0);
    end

    // Single write to register 1
    reset        = 1'b0;
    regWrEn      = 1'b1;
    regToWrite   = 2'd1;
    regWriteData = 32'hDEADBEEF;
    rSel1        = 2'd1;
    rSel2        = 2'd0;
    edge_step();
    chk("wr1_r1", reg1Out, 32'hDEADBEEF);
    chk("wr1_r2", reg2Out, 32'h0);
    chk("wr1_lane3", {24'h0, reg1Out[3]}, 32'h000000DE);
    chk("wr1_lane2", {24'h0, reg1Out[2]}, 32'h000000AD);
    chk("wr1_lane1", {24'h0, reg1Out[1]}, 32'h000000BE);
    chk("wr1_lane0", {24'h0, reg1Out[0]}, 32'h000000EF);

    // Second write to register 3
    regToWrite   = 2'd3;
    regWriteData = 32'h1A2B3C4D;
    rSel1        = 2'd3;
    edge_step();
    regWrEn = 1'b0;
    chk("wr3_r1", reg1Out, 32'h1A2B3C4D);
    chk("wr3_r2", reg2Out, 32'h0);
    chk("wr3_lane3", {24'h0, reg1Out[3]}, 32'h0000001A);
    chk("wr3_lane0", {24'h0, reg1Out[0]}, 32'h0000004D);

    // Dual read and swap
    rSel1 = 2'd1;
    rSel2 = 2'd3;
    #1;
    chk("dual_r1", reg1Out, 32'hDEADBEEF);
    chk("dual_r2", reg2Out, 32'h1A2B3C4D);
    rSel1 = 2'd3;
    rSel2 = 2'd1;
    #1;
    chk("swap_r1", reg1Out, 32'h1A2B3C4D);
    chk("swap_r2", reg2Out, 32'hDEADBEEF);
    rSel2 = 2'd2;
    #1;
    chk("unwritten_r2", reg2Out, 32'h0);

    // Enable low holds contents
    regWrEn      = 1'b0;
    regToWrite   = 2'd1;
    regWriteData = 32'h12345678;
    rSel1        = 2'd1;
    edge_step();
    edge_step();
    edge_step();
    chk("hold_r1", reg1Out, 32'hDEADBEEF);

    // No bypass: old value before the edge, new value after
    regWrEn = 1'b1;
    #1;
    chk("nobypass_before", reg1Out, 32'hDEADBEEF);
    edge_step();
    chk("nobypass_after", reg1Out, 32'h12345678);

    // Register 0 and register 2 are ordinary writable registers
    regToWrite   = 2'd0;
    regWriteData = 32'hA5A5A5A5;
    rSel1        = 2'd0;
    edge_step();
    regToWrite   = 2'd2;
    regWriteData = 32'h55AA33CC;
    rSel2        = 2'd2;
    edge_step();
    regWrEn = 1'b0;
    chk("reg0_write", reg1Out, 32'hA5A5A5A5);
    chk("reg2_write", reg2Out, 32'h55AA33CC);
    rSel1 = 2'd3;
    rSel2 = 2'd1;
    #1;
    chk("others_kept_r3", reg1Out, 32'h1A2B3C4D);
    chk("others_kept_r1", reg2Out, 32'h12345678);

    // Reset has priority over a same-edge write
    reset        = 1'b1;
    regWrEn      = 1'b1;
    regToWrite   = 2'd2;
    regWriteData = 32'hFFFFFFFF;
    edge_step();
    for (int i = 0; i < 4; i++) begin
      rSel1 = 2'(i);
      rSel2 = 2'(i);
      #1;
      chk($sformatf("rstprio_r1_%0d", i), reg1Out, 32'h0);
      chk($sformatf("rstprio_r2_%0d", i), reg2Out, 32'h0);
    end

    // Contents stay cleared while reset is held, even with writes requested
    rSel1 = 2'd2;
    edge_step();
    chk("rst_held_r2", reg1Out, 32'h0);

    // After release with enable low nothing changes
    reset   = 1'b0;
    regWrEn = 1'b0;
    edge_step();
    chk("post_rst_hold", reg1Out, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
